// File: rtl/y_mc_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Branch support is enabled with Y_MC_CTRL_BRANCH_EN.
package y_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LD,
    C_ST,
    C_BR,
    C_BAD
  } cls_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic cls_t opc2cls(
    input logic [6:0] opc
  );
    cls_t c;
    case (opc)
      OPC_R:   c = C_R;
      OPC_I:   c = C_I;
      OPC_LD:  c = C_LD;
      OPC_ST:  c = C_ST;
      OPC_BR:  c = C_BR;
      default: c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/y_alu_dec.sv
// ALU operation decode from instruction class and function bits.
// Combinational; valid=0 flags an unsupported funct3 or class.
module y_alu_dec
  import y_mc_pkg::*;
(
  input  cls_t       cls,
  input  logic [2:0] funct3,
  input  logic       b30,
  output logic [2:0] op,
  output logic       valid
);

  logic arith;

  assign arith = (cls == C_R) || (cls == C_I);

  always_comb begin
    op    = ALU_ADD;
    valid = 1'b1;
    unique case (1'b1)
      arith: begin
        case (funct3)
          3'b000: begin
            if ((cls == C_R) && b30)
              op = ALU_SUB;
            else
              op = ALU_ADD;
          end
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b010:  op = ALU_SLT;
          default: valid = 1'b0;
        endcase
      end
      (cls == C_LD) || (cls == C_ST): op = ALU_ADD;
      (cls == C_BR):                  op = ALU_SUB;
      default:                        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle RV32 subset control FSM (fetch/decode/exec/mem/wb).
// Define Y_MC_CTRL_BRANCH_EN to accept beq; otherwise it is illegal.
module y_mc_ctrl
  import y_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        ALUSrc,
  output logic [2:0]  op,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        branch_taken,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

`ifdef Y_MC_CTRL_BRANCH_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  state_t     st;
  state_t     nx;
  state_t     fin_nx;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       b30;
  logic       ill_q;
  cls_t       cls;
  logic [2:0] dop;
  logic       dvalid;
  logic       legal;
  logic       alu_on;

  assign cls   = opc2cls(opc);
  assign legal = dvalid && ((cls != C_BR) || BR_EN);

  y_alu_dec u_dec (
    .cls    (cls),
    .funct3 (f3),
    .b30    (b30),
    .op     (dop),
    .valid  (dvalid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      st <= S_IDLE;
    else
      st <= nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opc <= '0;
      f3  <= '0;
      b30 <= 1'b0;
    end else if ((st == S_FETCH) && mem_ready) begin
      opc <= ins[6:0];
      f3  <= ins[14:12];
      b30 <= ins[30];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ill_q <= 1'b0;
    else if ((st == S_IDLE) && run)
      ill_q <= 1'b0;
    else if ((st == S_DECODE) && !legal)
      ill_q <= 1'b1;
  end

  // Where an instruction goes once its final cycle is done
  assign fin_nx = run ? S_FETCH : S_IDLE;

  always_comb begin
    nx = st;
    case (st)
      S_IDLE:   if (run) nx = S_FETCH;
      S_FETCH:  if (mem_ready) nx = S_DECODE;
      S_DECODE: nx = legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (cls == C_BR)
          nx = fin_nx;
        else if ((cls == C_LD) || (cls == C_ST))
          nx = S_MEM;
        else
          nx = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          nx = (cls == C_LD) ? S_WB : fin_nx;
      end
      S_WB:     nx = fin_nx;
      default:  nx = S_IDLE;
    endcase
  end

  assign alu_on = (st == S_EXEC) || (st == S_MEM)
                || (st == S_WB);

  always_comb begin
    pc_write     = 1'b0;
    ALUSrc       = 1'b0;
    op           = ALU_AND;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Mem2Reg      = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    busy         = (st != S_IDLE);
    illegal      = ill_q;
    if (alu_on) begin
      op     = dop;
      ALUSrc = (cls == C_I) || (cls == C_LD)
             || (cls == C_ST);
    end
    unique case (1'b1)
      (st == S_FETCH): begin
        MemRead  = 1'b1;
        pc_write = mem_ready;
      end
      (st == S_EXEC): begin
        if (cls == C_BR) begin
          branch_taken = BR_EN & zero;
          pc_write     = BR_EN & zero;
          done         = 1'b1;
        end
      end
      (st == S_MEM): begin
        MemRead  = (cls == C_LD);
        MemWrite = (cls == C_ST);
        done     = (cls == C_ST) && mem_ready;
      end
      (st == S_WB): begin
        RegWrite = 1'b1;
        Mem2Reg  = (cls == C_LD);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Randomized bench for y_mc_ctrl with an instruction-level model.
// Honors Y_MC_CTRL_BRANCH_EN the same way as the design.
module tb_y_mc_ctrl;

`ifdef Y_MC_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  localparam logic [12:0] M_ALL = 13'h1FFF;
  localparam logic [12:0] M_NA  = 13'h10FF;

  logic        clk = 1'b0;
  logic        rstn;
  logic        run;
  logic [31:0] ins;
  logic        mem_ready;
  logic        zero;
  logic        pc_write;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;
  logic        branch_taken;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [12:0] outv;

  int checks = 0;
  int errors = 0;
  bit ill_m  = 1'b0;
  bit in_idle = 1'b1;

  y_mc_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .run          (run),
    .ins          (ins),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .pc_write     (pc_write),
    .ALUSrc       (ALUSrc),
    .op           (op),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Mem2Reg      (Mem2Reg),
    .branch_taken (branch_taken),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  assign outv = {pc_write, ALUSrc, op, RegWrite,
                 MemRead, MemWrite, Mem2Reg,
                 branch_taken, busy, done, illegal};

  task automatic chk(string tag, logic [12:0] obs,
                     logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ov(
    logic pcw, logic src, logic [2:0] o, logic rw,
    logic mrd, logic mwr, logic m2r, logic bt,
    logic bsy, logic dn, logic il);
    return {pcw, src, o, rw, mrd, mwr, m2r, bt,
            bsy, dn, il};
  endfunction

  task automatic step(string tag, logic [12:0] exp,
                      logic [12:0] m);
    @(negedge clk);
    chk(tag, outv & m, exp & m);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ins       = $urandom;
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    run       = 1'($urandom);
  endtask

  task automatic idle_until_run(int nlow);
    for (int k = 0; k < nlow; k++) begin
      noise();
      run = 1'b0;
      step("idle", ov(0,0,0,0,0,0,0,0,0,0,ill_m), M_NA);
    end
    noise();
    run = 1'b1;
    step("idle_go", ov(0,0,0,0,0,0,0,0,0,0,ill_m), M_NA);
    ill_m   = 1'b0;
    in_idle = 1'b0;
  endtask

  // zsel: 0/1 forces zero in EXEC, 2 randomizes it
  task automatic do_instr(logic [31:0] w, int fwait,
                          int mwait, bit run_end,
                          int zsel, bit rst_mem);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [2:0] eop;
    bit is_r, is_i, is_ld, is_st, is_br;
    bit legal, esrc, f3ok, mr;
    opc   = w[6:0];
    f3    = w[14:12];
    is_r  = (opc == 7'h33);
    is_i  = (opc == 7'h13);
    is_ld = (opc == 7'h03);
    is_st = (opc == 7'h23);
    is_br = (opc == 7'h63) && BR_EN;
    f3ok  = (f3 == 3'd0) || (f3 == 3'd7)
          || (f3 == 3'd6) || (f3 == 3'd2);
    legal = ((is_r || is_i) && f3ok)
          || is_ld || is_st || is_br;
    esrc  = is_i || is_ld || is_st;
    eop   = 3'b010;
    if (is_br) eop = 3'b110;
    if (is_r || is_i) begin
      case (f3)
        3'd0: eop = (is_r && w[30]) ? 3'b110 : 3'b010;
        3'd7: eop = 3'b000;
        3'd6: eop = 3'b001;
        default: eop = 3'b111;
      endcase
    end
    if (in_idle) idle_until_run($urandom_range(0, 2));
    for (int k = 0; k <= fwait; k++) begin
      noise();
      mem_ready = (k == fwait);
      if (k == fwait) ins = w;
      step("fetch", ov(k == fwait,0,0,0,1,0,0,0,1,0,ill_m),
           M_NA);
    end
    noise();
    step("decode", ov(0,0,0,0,0,0,0,0,1,0,ill_m), M_NA);
    if (!legal) begin
      ill_m   = 1'b1;
      in_idle = 1'b1;
      return;
    end
    noise();
    if (zsel < 2) zero = zsel[0];
    if (is_br) run = run_end;
    step("exec", ov(is_br & zero, esrc, eop, 0, 0, 0, 0,
                    is_br & zero, 1, is_br, 0), M_ALL);
    if (is_br) begin
      in_idle = !run_end;
      return;
    end
    if (is_ld || is_st) begin
      for (int k = 0; k <= mwait; k++) begin
        noise();
        mr = (k == mwait);
        mem_ready = mr;
        if (is_st && mr) run = run_end;
        if (rst_mem && k == 0) begin
          mem_ready = 1'b1;
          run = 1'b0;
          #2 rstn = 1'b0;
          #1 chk("rst_mem", outv, 13'h0);
          @(posedge clk);
          #1 chk("rst_hold", outv, 13'h0);
          rstn    = 1'b1;
          ill_m   = 1'b0;
          in_idle = 1'b1;
          return;
        end
        step("mem", ov(0, esrc, eop, 0, is_ld, is_st, 0, 0,
                       1, is_st & mr, 0), M_ALL);
      end
      if (is_st) begin
        in_idle = !run_end;
        return;
      end
    end
    noise();
    run = run_end;
    step("wb", ov(0, esrc, eop, 1, 0, 0, is_ld, 0, 1, 1, 0),
         M_ALL);
    in_idle = !run_end;
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  opcs [5];
    opcs[0] = 7'h33;
    opcs[1] = 7'h13;
    opcs[2] = 7'h03;
    opcs[3] = 7'h23;
    opcs[4] = 7'h63;
    rstn = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    ins = 32'h0;
    #1 chk("reset", outv, 13'h0);
    @(posedge clk);
    #1 chk("reset_run", outv, 13'h0);
    run = 1'b0;
    rstn = 1'b1;
    idle_until_run(2);
    do_instr(32'h002081B3, 0, 0, 1, 2, 0);
    do_instr(32'h402081B3, 1, 0, 1, 2, 0);
    do_instr(32'h0080A283, 0, 3, 1, 2, 0);
    do_instr(32'h0050A423, 0, 0, 1, 2, 0);
    do_instr(32'h00208463, 0, 0, 1, 1, 0);
    do_instr(32'h00208463, 0, 0, 0, 0, 0);
    do_instr(32'hFFFFFFFF, 0, 0, 1, 2, 0);
    do_instr(32'h002081B3, 0, 0, 0, 2, 0);
    do_instr(32'h0080A283, 0, 2, 1, 2, 1);
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      if ($urandom_range(0, 5) != 0)
        w[6:0] = opcs[$urandom_range(0, 4)];
      do_instr(w, $urandom_range(0, 2),
               $urandom_range(0, 3), 1'($urandom),
               2, 0);
    end
    do_instr(32'h0080A283, 0, 1, 1, 2, 1);
    run = 1'b0;
    step("final_idle", ov(0,0,0,0,0,0,0,0,0,0,0), M_ALL);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
